// File: rtl/lab62soc_irq_ctrl_0.sv
// Avalon-MM interrupt controller: latches NUM_IRQ sources into a pending register and drives a masked, registered irq.
// Optional build macro LAB62_IRQ_SYNC_EN adds a two-flop synchronizer on every irq_in bit.
module lab62soc_irq_ctrl_0 #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ID_W   = 4;

    localparam logic [2:0] ADDR_PENDING   = 3'd0;
    localparam logic [2:0] ADDR_MASK      = 3'd1;
    localparam logic [2:0] ADDR_EDGE_SEL  = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE_ID = 3'd3;
    localparam logic [2:0] ADDR_SW_SET    = 3'd4;
    localparam logic [2:0] ADDR_ACK       = 3'd5;

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] edge_sel;
    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] prev;

    logic               wr;
    logic [NUM_IRQ-1:0] set_vec;
    logic [NUM_IRQ-1:0] clr_vec;
    logic [NUM_IRQ-1:0] active;
    logic               id_valid;
    logic [ID_W-1:0]    id;
    logic [DATA_W-1:0]  rd_mux;
    logic               unused_bits;

    assign wr          = chipselect && !write_n;
    assign active      = pending & mask;
    assign unused_bits = &{1'b0, writedata};

`ifdef LAB62_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1;
    logic [NUM_IRQ-1:0] sync2;

    // Two-flop synchronizer for asynchronous sources.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = irq_in;
`endif

    // Set and clear requests; ACK indices outside the source range decode to nothing.
    always_comb begin
        set_vec = (edge_sel & s & ~prev) | (~edge_sel & s);
        clr_vec = '0;
        if (wr && address == ADDR_SW_SET) begin
            set_vec = set_vec | writedata[NUM_IRQ-1:0];
        end
        if (wr && address == ADDR_PENDING) begin
            clr_vec = writedata[NUM_IRQ-1:0];
        end
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (wr && address == ADDR_ACK && writedata[ID_W-1:0] == ID_W'(i)) begin
                clr_vec[i] = 1'b1;
            end
        end
    end

    // Lowest-numbered enabled pending source wins.
    always_comb begin
        id_valid = |active;
        id       = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (active[i]) begin
                id = ID_W'(i);
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_PENDING:   rd_mux = DATA_W'(pending);
            ADDR_MASK:      rd_mux = DATA_W'(mask);
            ADDR_EDGE_SEL:  rd_mux = DATA_W'(edge_sel);
            ADDR_ACTIVE_ID: rd_mux = {id_valid, 11'd0, id};
            default:        rd_mux = '0;
        endcase
    end

    // Register file, pending latch and registered outputs; set beats clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            mask     <= '0;
            edge_sel <= '0;
            prev     <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            prev     <= s;
            pending  <= set_vec | (pending & ~clr_vec);
            readdata <= rd_mux;
            irq      <= |active;
            if (wr && address == ADDR_MASK) begin
                mask <= writedata[NUM_IRQ-1:0];
            end
            if (wr && address == ADDR_EDGE_SEL) begin
                edge_sel <= writedata[NUM_IRQ-1:0];
            end
        end
    end

endmodule

// File: tb/tb_lab62soc_irq_ctrl_0.sv
// Directed self-checking bench for lab62soc_irq_ctrl_0 (default build, NUM_IRQ = 8).
module tb_lab62soc_irq_ctrl_0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = 16'd0;
    logic [15:0] readdata;
    logic [7:0]  irq_in = 8'd0;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    lab62soc_irq_ctrl_0 #(.NUM_IRQ(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Address held across two edges so the sample is stable regardless of phase.
    task automatic bus_rd(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        address = a;
        @(posedge clk);
        @(posedge clk);
        #1;
        d = readdata;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] rd;

    initial begin
        // Reset state
        #12;
        check("rst_irq", {15'd0, irq}, 16'h0000);
        check("rst_readdata", readdata, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 3; a++) begin
            bus_rd(3'(a), rd);
            check($sformatf("rst_reg%0d", a), rd, 16'h0000);
        end

        // Bounds: bits above NUM_IRQ-1 are dropped
        bus_wr(3'd1, 16'hFFFF);
        bus_rd(3'd1, rd);
        check("mask_ffff", rd, 16'h00FF);
        bus_wr(3'd4, 16'hFFFF);
        bus_rd(3'd0, rd);
        check("swset_ffff", rd, 16'h00FF);
        check("swset_irq", {15'd0, irq}, 16'h0001);
        bus_wr(3'd0, 16'hFFFF);
        check("w1c_irq_lag", {15'd0, irq}, 16'h0001);
        cycles(1);
        check("w1c_irq_low", {15'd0, irq}, 16'h0000);
        bus_rd(3'd0, rd);
        check("w1c_all", rd, 16'h0000);
        for (int a = 4; a < 8; a++) begin
            bus_rd(3'(a), rd);
            check($sformatf("rd_zero%0d", a), rd, 16'h0000);
        end

        // Level source 0
        bus_wr(3'd1, 16'h0001);
        @(negedge clk);
        irq_in[0] = 1'b1;
        cycles(4);
        check("lvl_irq", {15'd0, irq}, 16'h0001);
        bus_wr(3'd0, 16'h0001);
        bus_rd(3'd0, rd);
        check("lvl_reassert", rd, 16'h0001);
        @(negedge clk);
        irq_in[0] = 1'b0;
        cycles(2);
        bus_wr(3'd0, 16'h0001);
        check("lvl_clr_lag", {15'd0, irq}, 16'h0001);
        cycles(1);
        check("lvl_clr_irq", {15'd0, irq}, 16'h0000);
        bus_rd(3'd0, rd);
        check("lvl_clr_pend", rd, 16'h0000);

        // Set beats clear: level source 1 held while W1C hits it
        @(negedge clk);
        irq_in[1] = 1'b1;
        cycles(3);
        bus_wr(3'd0, 16'h0002);
        check("setclr_pend_now", {8'd0, dut.pending}, 16'h0002);
        bus_rd(3'd0, rd);
        check("setclr_pend", rd, 16'h0002);
        @(negedge clk);
        irq_in[1] = 1'b0;
        cycles(2);
        bus_wr(3'd0, 16'h0002);

        // Edge source 2
        bus_wr(3'd2, 16'h0004);
        bus_wr(3'd1, 16'h0004);
        bus_rd(3'd2, rd);
        check("edge_sel_rb", rd, 16'h0004);
        @(negedge clk);
        irq_in[2] = 1'b1;
        cycles(3);
        bus_rd(3'd0, rd);
        check("edge1_pend", rd, 16'h0004);
        check("edge1_irq", {15'd0, irq}, 16'h0001);
        bus_wr(3'd5, 16'h0002);
        cycles(1);
        check("ack2_irq", {15'd0, irq}, 16'h0000);
        bus_rd(3'd0, rd);
        check("edge_held_no_reset", rd, 16'h0000);
        @(negedge clk);
        irq_in[2] = 1'b0;
        cycles(3);
        @(negedge clk);
        irq_in[2] = 1'b1;
        cycles(3);
        @(negedge clk);
        irq_in[2] = 1'b0;
        cycles(2);
        check("edge2_irq", {15'd0, irq}, 16'h0001);
        bus_wr(3'd5, 16'h000C);
        bus_rd(3'd0, rd);
        check("ack12_ignored", rd, 16'h0004);
        bus_wr(3'd5, 16'h0002);
        bus_wr(3'd2, 16'h0000);
        bus_rd(3'd0, rd);
        check("edge_cleared", rd, 16'h0000);

        // Priority / ACTIVE_ID
        bus_wr(3'd1, 16'h00FF);
        bus_wr(3'd4, 16'h00A0);
        bus_rd(3'd3, rd);
        check("id_5", rd, 16'h8005);
        bus_wr(3'd5, 16'h0005);
        bus_rd(3'd3, rd);
        check("id_7", rd, 16'h8007);
        bus_wr(3'd5, 16'h0007);
        bus_rd(3'd3, rd);
        check("id_none", rd, 16'h0000);
        check("id_none_irq", {15'd0, irq}, 16'h0000);

        // Asynchronous reset mid-traffic
        bus_wr(3'd4, 16'h0001);
        cycles(2);
        check("pre_rst_irq", {15'd0, irq}, 16'h0001);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_irq", {15'd0, irq}, 16'h0000);
        check("async_rst_rd", readdata, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 3; a++) begin
            bus_rd(3'(a), rd);
            check($sformatf("post_rst_reg%0d", a), rd, 16'h0000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
